decode_stage: RTL and testbench

Second stage of the five-stage pipelined processor, directly downstream of fetch. It holds the IF/ID pipeline register and the 32×32 register file, and splits instruction fields. It resolves branches and jumps early in decode and drives the next-PC value back into fetch's PC input. Control decode and hazard detection are external; this block consumes their `BranchD`, `JumpD`, `StallD`, `FlushD` and `Forward*D` signals.

---
 rtl/decode_stage.sv | 123 ++++++++++++
 tb/tb_decode_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, 32x32 register file with write-through,
// and early branch/jump resolution feeding the next PC back to fetch.
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCPlus4F,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  input  logic [31:0] ALUOutM,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic        BranchD,
  input  logic        JumpD,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic [5:0]  OpD,
  output logic [5:0]  FunctD,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic [4:0]  RdD,
  output logic [31:0] SignImmD,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] PCBranchD,
  output logic [31:0] PCJumpD,
  output logic        PCSrcD,
  output logic [31:0] PCinF
);

  logic [31:0] r_instr;
  logic [31:0] r_pcplus4;
  logic [31:0] r_regs [32];

  logic        w_wen;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_cmp_a;
  logic [31:0] w_cmp_b;
  logic [31:0] w_simm;
  logic [31:0] w_pcbranch;
  logic [31:0] w_pcjump;
  logic        w_pcsrc;
  logic [31:0] w_pcin;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_instr   <= '0;
      r_pcplus4 <= '0;
    end else if (!StallD) begin
      if (FlushD) begin
        r_instr   <= '0;
        r_pcplus4 <= '0;
      end else begin
        r_instr   <= InstrF;
        r_pcplus4 <= PCPlus4F;
      end
    end
  end

  assign w_wen = RegWriteW && (WriteRegW != 5'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        r_regs[i] <= '0;
    end else if (w_wen) begin
      r_regs[WriteRegW] <= ResultW;
    end
  end

  assign InstrD   = r_instr;
  assign PCPlus4D = r_pcplus4;
  assign OpD      = r_instr[31:26];
  assign FunctD   = r_instr[5:0];
  assign RsD      = r_instr[25:21];
  assign RtD      = r_instr[20:16];
  assign RdD      = r_instr[15:11];
  assign w_simm   = {{16{r_instr[15]}}, r_instr[15:0]};
  assign SignImmD = w_simm;

  // bypass stands in for the classic write-first-half / read-second-half
  always_comb begin
    w_rd1 = r_regs[RsD];
    w_rd2 = r_regs[RtD];
    if (w_wen && (WriteRegW == RsD))
      w_rd1 = ResultW;
    if (w_wen && (WriteRegW == RtD))
      w_rd2 = ResultW;
    if (RsD == 5'd0)
      w_rd1 = '0;
    if (RtD == 5'd0)
      w_rd2 = '0;
  end

  assign RD1D = w_rd1;
  assign RD2D = w_rd2;

  assign w_cmp_a = ForwardAD ? ALUOutM : w_rd1;
  assign w_cmp_b = ForwardBD ? ALUOutM : w_rd2;
  assign w_pcsrc = BranchD && (w_cmp_a == w_cmp_b);

  assign w_pcbranch = r_pcplus4 + {w_simm[29:0], 2'b00};
  assign w_pcjump   = {r_pcplus4[31:28], r_instr[25:0], 2'b00};

  always_comb begin
    w_pcin = PCPlus4F;
    priority case (1'b1)
      JumpD:   w_pcin = w_pcjump;
      w_pcsrc: w_pcin = w_pcbranch;
      default: w_pcin = PCPlus4F;
    endcase
  end

  assign PCSrcD    = w_pcsrc;
  assign PCBranchD = w_pcbranch;
  assign PCJumpD   = w_pcjump;
  assign PCinF     = w_pcin;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        StallD, FlushD;
  logic [31:0] InstrF, PCPlus4F;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW, ALUOutM;
  logic        ForwardAD, ForwardBD, BranchD, JumpD;
  logic [31:0] InstrD, PCPlus4D;
  logic [5:0]  OpD, FunctD;
  logic [4:0]  RsD, RtD, RdD;
  logic [31:0] SignImmD, RD1D, RD2D, PCBranchD, PCJumpD, PCinF;
  logic        PCSrcD;

  decode_stage dut (
    .clock(clock), .reset(reset),
    .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .ALUOutM(ALUOutM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .BranchD(BranchD), .JumpD(JumpD),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .OpD(OpD), .FunctD(FunctD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .SignImmD(SignImmD), .RD1D(RD1D), .RD2D(RD2D),
    .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
    .PCSrcD(PCSrcD), .PCinF(PCinF)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  int unsigned m_instr, m_pc;
  int unsigned m_regs [32];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned m_read(int unsigned r);
    if (r == 0) return 0;
    if (RegWriteW && WriteRegW == r) return ResultW;
    return m_regs[r];
  endfunction

  task automatic m_reset();
    m_instr = 0;
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  task automatic check_all(string pfx);
    int unsigned rs, rt, rd1, rd2, a, b, simm, pcb, pcj, pin;
    logic signed [15:0] imm;
    logic src;
    rs   = (m_instr >> 21) % 32;
    rt   = (m_instr >> 16) % 32;
    imm  = m_instr[15:0];
    simm = int'(imm);
    rd1  = m_read(rs);
    rd2  = m_read(rt);
    a    = ForwardAD ? ALUOutM : rd1;
    b    = ForwardBD ? ALUOutM : rd2;
    src  = BranchD && (a == b);
    pcb  = m_pc + simm * 4;
    pcj  = (m_pc & 32'hF000_0000) | ((m_instr % (1 << 26)) * 4);
    pin  = JumpD ? pcj : (src ? pcb : PCPlus4F);
    chk({pfx, ".InstrD"}, InstrD, m_instr);
    chk({pfx, ".PCPlus4D"}, PCPlus4D, m_pc);
    chk({pfx, ".OpD"}, 32'(OpD), m_instr >> 26);
    chk({pfx, ".FunctD"}, 32'(FunctD), m_instr % 64);
    chk({pfx, ".RsD"}, 32'(RsD), rs);
    chk({pfx, ".RtD"}, 32'(RtD), rt);
    chk({pfx, ".RdD"}, 32'(RdD), (m_instr >> 11) % 32);
    chk({pfx, ".SignImmD"}, SignImmD, simm);
    chk({pfx, ".RD1D"}, RD1D, rd1);
    chk({pfx, ".RD2D"}, RD2D, rd2);
    chk({pfx, ".PCBranchD"}, PCBranchD, pcb);
    chk({pfx, ".PCJumpD"}, PCJumpD, pcj);
    chk({pfx, ".PCSrcD"}, 32'(PCSrcD), 32'(src));
    chk({pfx, ".PCinF"}, PCinF, pin);
  endtask

  task automatic cycle(string pfx);
    #1;
    check_all(pfx);
    @(posedge clock);
    if (reset) begin
      if (RegWriteW && WriteRegW != 0) m_regs[WriteRegW] = ResultW;
      if (!StallD) begin
        m_instr = FlushD ? 0 : InstrF;
        m_pc    = FlushD ? 0 : PCPlus4F;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    StallD = 0; FlushD = 0; RegWriteW = 0; WriteRegW = 0;
    ResultW = 0; ALUOutM = 0; ForwardAD = 0; ForwardBD = 0;
    BranchD = 0; JumpD = 0;
  endtask

  task automatic load(int unsigned ins, int unsigned pc);
    InstrF = ins; PCPlus4F = pc;
    cycle("load");
  endtask

  task automatic wr(int unsigned r, int unsigned v);
    RegWriteW = 1; WriteRegW = 5'(r); ResultW = v;
    cycle("wr");
    RegWriteW = 0;
  endtask

  initial begin
    idle();
    InstrF = 0; PCPlus4F = 0;
    reset = 0;
    m_reset();
    #1;
    check_all("rst");
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    cycle("rel");

    // reset mid-operation, with a write pending while reset is low
    wr(3, 32'h55);
    load(32'h8C22_0004, 32'h10);
    chk("pre_rst.InstrD", InstrD, 32'h8C22_0004);
    #2;
    reset = 0;
    m_reset();
    #1;
    chk("mid_rst.InstrD", InstrD, 0);
    chk("mid_rst.PCPlus4D", PCPlus4D, 0);
    check_all("mid_rst");
    RegWriteW = 1; WriteRegW = 3; ResultW = 32'h99;
    @(posedge clock);
    @(negedge clock);
    RegWriteW = 0;
    reset = 1;
    load(32'h0060_0000, 32'h4);
    chk("r3_after_rst", RD1D, 0);

    // write-through bypass and $0
    load(32'h00A0_0000, 32'h8);
    RegWriteW = 1; WriteRegW = 5; ResultW = 32'h1234;
    #1;
    chk("bypass.same", RD1D, 32'h1234);
    cycle("bypass");
    #1;
    chk("bypass.array", RD1D, 32'h1234);
    load(32'h0000_0000, 32'hC);
    RegWriteW = 1; WriteRegW = 0; ResultW = 32'hFFFF;
    #1;
    chk("r0.same", RD1D, 0);
    cycle("r0");
    RegWriteW = 0;
    #1;
    chk("r0.after", RD1D, 0);

    // taken beq, negative offset
    InstrF = 32'h1109_FFFF; PCPlus4F = 32'h100;
    wr(8, 7);
    wr(9, 7);
    BranchD = 1;
    #1;
    chk("beq.SignImmD", SignImmD, 32'hFFFF_FFFF);
    chk("beq.PCBranchD", PCBranchD, 32'hFC);
    chk("beq.PCSrcD", 32'(PCSrcD), 1);
    chk("beq.PCinF", PCinF, 32'hFC);
    cycle("beq");

    // forwarded compare
    BranchD = 0;
    wr(8, 1);
    BranchD = 1; ForwardAD = 1; ALUOutM = 7;
    #1;
    chk("fwd.PCSrcD", 32'(PCSrcD), 1);
    cycle("fwd");
    ForwardAD = 0; PCPlus4F = 32'h204;
    #1;
    chk("nofwd.PCSrcD", 32'(PCSrcD), 0);
    chk("nofwd.PCinF", PCinF, 32'h204);
    cycle("nofwd");
    idle();

    // jump, and jump beating a taken branch
    load(32'h0800_0010, 32'h4000_0004);
    JumpD = 1;
    #1;
    chk("j.PCJumpD", PCJumpD, 32'h4000_0040);
    chk("j.PCinF", PCinF, 32'h4000_0040);
    BranchD = 1;
    #1;
    chk("jb.PCSrcD", 32'(PCSrcD), 1);
    chk("jb.PCinF", PCinF, 32'h4000_0040);
    StallD = 1;
    cycle("jb");
    idle();

    // stall vs flush
    load(32'h1234_5678, 32'h50);
    StallD = 1; FlushD = 1; InstrF = 32'hDEAD_BEEF; PCPlus4F = 32'h60;
    cycle("sf");
    chk("stall.InstrD", InstrD, 32'h1234_5678);
    chk("stall.PCPlus4D", PCPlus4D, 32'h50);
    StallD = 0;
    cycle("fl");
    chk("flush.InstrD", InstrD, 0);
    chk("flush.PCPlus4D", PCPlus4D, 0);
    FlushD = 0;
    cycle("go");
    chk("cap.InstrD", InstrD, 32'hDEAD_BEEF);

    // randomized traffic on a small operand set so compares often match
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      InstrF    = ins;
      PCPlus4F  = $urandom;
      StallD    = ($urandom_range(0, 9) == 0);
      FlushD    = ($urandom_range(0, 9) == 0);
      RegWriteW = $urandom_range(0, 1);
      WriteRegW = 5'($urandom_range(0, 4));
      ResultW   = $urandom_range(0, 3);
      ALUOutM   = $urandom_range(0, 3);
      ForwardAD = ($urandom_range(0, 4) == 0);
      ForwardBD = ($urandom_range(0, 4) == 0);
      BranchD   = $urandom_range(0, 1);
      JumpD     = ($urandom_range(0, 3) == 0);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
